pwm_fader: RTL and testbench

PWM_FADER -- requirements
Module: pwm_fader

---
 rtl/pwm_fader.sv | 149 ++++++++++++++
 tb/tb_pwm_fader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fader.sv
// pwm_fader: multi-channel PWM generator with linear level fading.
// Each channel's level walks one LSB at a time toward a latched target,
// paced by a prescaler. A free-running counter compares against a per-channel
// duty register. That duty register only takes a new level at the counter
// wrap, so a PWM period is never disturbed mid-way.
module pwm_fader #(
  parameter int NCH  = 3,
  parameter int NBPC = 8,
  parameter int RW   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [NCH*NBPC-1:0] target,
  input  logic [RW-1:0]       rate,
  output logic [NCH*NBPC-1:0] level,
  output logic [NCH-1:0]      pwm,
  output logic                busy,
  output logic                period
);

  localparam logic [NBPC-1:0] MAX  = {NBPC{1'b1}};
  localparam logic [NBPC-1:0] LAST = MAX - 1'b1;

  typedef enum logic {IDLE = 1'b0, FADE = 1'b1} state_t;

  state_t          state_q;

  logic [NBPC-1:0] cnt_q,   cnt_d;
  logic [RW-1:0]   presc_q, presc_d;
  logic [RW-1:0]   rate_q,  rate_d;
  logic [NBPC-1:0] level_q [NCH];
  logic [NBPC-1:0] level_d [NCH];
  logic [NBPC-1:0] tgt_q   [NCH];
  logic [NBPC-1:0] tgt_d   [NCH];
  logic [NBPC-1:0] duty_q  [NCH];
  logic [NBPC-1:0] duty_d  [NCH];
  logic [NCH-1:0]  pwm_q,   pwm_d;

  logic            load_v;
  logic            wrap;
  logic            tick;
  logic            any_diff_d;

  // One LSB toward the goal; a channel already at its goal stays put. The
  // compare-before-move means the level can never run past 0 or MAX.
  function automatic logic [NBPC-1:0] step_toward(input logic [NBPC-1:0] cur,
                                                  input logic [NBPC-1:0] goal);
    if (cur < goal) begin
      return cur + 1'b1;
    end else if (cur > goal) begin
      return cur - 1'b1;
    end else begin
      return cur;
    end
  endfunction

  // Next-state logic for counter, prescaler, targets, levels, duty and pwm.
  always_comb begin
    load_v   = en & load;
    wrap     = en && (cnt_q == LAST);
    // A load in the same cycle as a due step suppresses the step.
    tick     = en && !load_v && (state_q == FADE) && (presc_q == rate_q);

    cnt_d    = cnt_q;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    rate_d   = load_v ? rate : rate_q;

    presc_d  = presc_q;
    if (en) begin
      if (load_v) begin
        presc_d = '0;
      end else if (state_q == FADE) begin
        presc_d = tick ? '0 : presc_q + 1'b1;
      end else begin
        presc_d = '0;
      end
    end

    any_diff_d = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      tgt_d[k]   = load_v ? target[k*NBPC +: NBPC] : tgt_q[k];
      level_d[k] = tick ? step_toward(level_q[k], tgt_q[k]) : level_q[k];
      duty_d[k]  = wrap ? level_q[k] : duty_q[k];
      // Counter never exceeds MAX-1, so duty MAX yields a constant 1.
      pwm_d[k]   = en && (cnt_q < duty_q[k]);
      if (level_d[k] != tgt_d[k]) begin
        any_diff_d = 1'b1;
      end
    end
  end

  // Datapath registers; everything holds while en is low except pwm, which drops to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      presc_q <= '0;
      rate_q  <= '0;
      pwm_q   <= '0;
      for (int k = 0; k < NCH; k++) begin
        level_q[k] <= '0;
        tgt_q[k]   <= '0;
        duty_q[k]  <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      rate_q  <= rate_d;
      pwm_q   <= pwm_d;
      for (int k = 0; k < NCH; k++) begin
        level_q[k] <= level_d[k];
        tgt_q[k]   <= tgt_d[k];
        duty_q[k]  <= duty_d[k];
      end
    end
  end

  // Fade FSM. It compares next levels against next targets, so busy rises on
  // the same edge that latches a new target and falls on the edge of the
  // final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (en) begin
      case (state_q)
        IDLE:    if (any_diff_d)  state_q <= FADE;
        FADE:    if (!any_diff_d) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output packing, channel k in bits [(k+1)*NBPC-1 : k*NBPC].
  always_comb begin
    level = '0;
    for (int k = 0; k < NCH; k++) begin
      level[k*NBPC +: NBPC] = level_q[k];
    end
  end

  assign pwm    = pwm_q;
  assign busy   = (state_q == FADE);
  assign period = wrap;

endmodule

// File: tb/tb_pwm_fader.sv
// Testbench for pwm_fader (NCH=3, NBPC=4, RW=8).
// Stimulus is pushed through a behavioural model into a scoreboard queue. A
// monitor on the falling edge pops and compares. Directed scenarios add
// absolute checks against hand-derived values.
module tb_pwm_fader;

  localparam int NCH  = 3;
  localparam int NBPC = 4;
  localparam int RW   = 8;
  localparam int MAX  = 15;

  logic                clk = 1'b0;
  logic                rst, en, load;
  logic [NCH*NBPC-1:0] target;
  logic [RW-1:0]       rate;
  logic [NCH*NBPC-1:0] level;
  logic [NCH-1:0]      pwm;
  logic                busy, period;

  always #5 clk = ~clk;

  pwm_fader #(.NCH(NCH), .NBPC(NBPC), .RW(RW)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .target(target), .rate(rate),
    .level(level), .pwm(pwm), .busy(busy), .period(period)
  );

  typedef struct {
    int                  tag;
    logic [NCH*NBPC-1:0] level;
    logic [NCH-1:0]      pwm;
    logic                busy;
    logic                period;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   idx    = 0;

  // Behavioural reference state
  int       m_cnt, m_presc, m_rate;
  int       m_lvl[NCH], m_tgt[NCH], m_duty[NCH];
  bit       m_fade;
  bit [2:0] m_pwm;

  function automatic void check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0d, expected %0d", name, idx, got, exp);
  endfunction

  function automatic logic [NCH*NBPC-1:0] m_pack();
    logic [NCH*NBPC-1:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++) v[k*NBPC +: NBPC] = m_lvl[k][NBPC-1:0];
    return v;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_presc = 0; m_rate = 0; m_fade = 0; m_pwm = '0;
    for (int k = 0; k < NCH; k++) begin
      m_lvl[k] = 0; m_tgt[k] = 0; m_duty[k] = 0;
    end
  endtask

  // Advances the model by one clock with the given inputs.
  task automatic model_step(input bit r, input bit e, input bit l,
                            input logic [NCH*NBPC-1:0] t, input logic [RW-1:0] rt);
    bit [2:0] np;
    if (r) begin
      model_reset();
      return;
    end
    if (!e) begin
      m_pwm = '0;
      return;
    end
    for (int k = 0; k < NCH; k++) np[k] = (m_cnt < m_duty[k]);
    if (m_cnt == MAX - 1) for (int k = 0; k < NCH; k++) m_duty[k] = m_lvl[k];
    m_cnt = (m_cnt + 1) % MAX;
    if (l) begin
      for (int k = 0; k < NCH; k++) m_tgt[k] = int'(t[k*NBPC +: NBPC]);
      m_rate  = int'(rt);
      m_presc = 0;
    end else if (m_fade) begin
      if (m_presc == m_rate) begin
        for (int k = 0; k < NCH; k++) begin
          if (m_lvl[k] < m_tgt[k]) m_lvl[k]++;
          else if (m_lvl[k] > m_tgt[k]) m_lvl[k]--;
        end
        m_presc = 0;
      end else begin
        m_presc++;
      end
    end
    m_fade = 0;
    for (int k = 0; k < NCH; k++) if (m_lvl[k] != m_tgt[k]) m_fade = 1;
    m_pwm = np;
  endtask

  task automatic push_exp();
    exp_t x;
    x.tag    = idx;
    x.level  = m_pack();
    x.pwm    = m_pwm;
    x.busy   = m_fade;
    x.period = en && (m_cnt == MAX - 1);
    sb.push_back(x);
  endtask

  // Drive one cycle: apply inputs, record what the DUT must show now, advance
  // the model across the coming edge, then wait just past that edge.
  task automatic cyc(input bit r, input bit e, input bit l,
                     input logic [NCH*NBPC-1:0] t, input logic [RW-1:0] rt);
    rst = r; en = e; load = l; target = t; rate = rt;
    push_exp();
    model_step(r, e, l, t, rt);
    @(posedge clk);
    #1;
    idx++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 12'h000, 8'd0);
  endtask

  // Scoreboard monitor
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].tag <= idx) begin
        x = sb.pop_front();
        check("sb_level",  int'(level),  int'(x.level));
        check("sb_pwm",    int'(pwm),    int'(x.pwm));
        check("sb_busy",   int'(busy),   int'(x.busy));
        check("sb_period", int'(period), int'(x.period));
      end
    end
  end

  initial begin
    int                  h[NCH];
    int                  first_per;
    int                  prev, cur, bad;
    bit                  found;
    logic [NCH*NBPC-1:0] saved;

    rst = 1'b1; en = 1'b0; load = 1'b0; target = '0; rate = '0;
    model_reset();
    @(posedge clk); #1; idx = 1;

    // Reset wins over a simultaneous enabled load
    cyc(1'b1, 1'b1, 1'b1, 12'hFFF, 8'd5);
    check("rst_level", int'(level), 0);
    check("rst_busy",  int'(busy),  0);
    check("rst_pwm",   int'(pwm),   0);
    run(3);

    // Fade up to {15,8,0} at one LSB per clock
    cyc(1'b0, 1'b1, 1'b1, 12'hF80, 8'd0);
    check("s1_busy_rise", int'(busy), 1);
    run(14);
    check("s1_level_14", int'(level), 12'hE80);
    check("s1_busy_14",  int'(busy),  1);
    run(1);
    check("s1_level_15", int'(level), 12'hF80);
    check("s1_busy_15",  int'(busy),  0);

    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      run(1);
      if (period) found = 1'b1;
    end
    check("s1_wrap_seen", int'(found), 1);
    run(1);
    for (int k = 0; k < NCH; k++) h[k] = 0;
    first_per = 0;
    for (int i = 1; i <= MAX; i++) begin
      run(1);
      for (int k = 0; k < NCH; k++) h[k] += int'(pwm[k]);
      if (period && first_per == 0) first_per = i;
    end
    check("s1_pwm2_high", h[2], 15);
    check("s1_pwm1_high", h[1], 8);
    check("s1_pwm0_high", h[0], 0);
    check("s1_period_spacing", first_per, 14);

    // All channels to 15, then fade down to 0 at rate 3
    cyc(1'b0, 1'b1, 1'b1, 12'hFFF, 8'd0);
    run(15);
    check("s2_level_full", int'(level), 12'hFFF);
    cyc(1'b0, 1'b1, 1'b1, 12'h000, 8'd3);
    prev = 15; bad = 0;
    for (int i = 1; i <= 60; i++) begin
      run(1);
      cur = int'(level[3:0]);
      if (cur > prev || prev - cur > 1) bad++;
      if (i == 4)  check("s2_first_step", int'(level), 12'hEEE);
      if (i == 59) check("s2_level_59", int'(level), 12'h111);
      prev = cur;
    end
    check("s2_level_60", int'(level), 12'h000);
    check("s2_busy_60",  int'(busy),  0);
    check("s2_monotone", bad, 0);
    run(8);
    check("s2_no_underflow", int'(level), 12'h000);

    // Re-target mid-fade; the load coincides with a due step
    cyc(1'b0, 1'b1, 1'b1, 12'hCCC, 8'd1);
    run(13);
    check("s3_level_6", int'(level), 12'h666);
    cyc(1'b0, 1'b1, 1'b1, 12'h222, 8'd1);
    check("s3_load_wins", int'(level), 12'h666);
    run(1);
    check("s3_no_jump", int'(level), 12'h666);
    run(1);
    check("s3_step_to_5", int'(level), 12'h555);
    run(5);
    check("s3_level_3", int'(level), 12'h333);
    check("s3_busy_3",  int'(busy),  1);
    run(1);
    check("s3_level_2", int'(level), 12'h222);
    check("s3_busy_2",  int'(busy),  0);

    // Freeze with en low for 20 cycles mid-fade; loads are ignored
    cyc(1'b0, 1'b1, 1'b1, 12'hFFF, 8'd2);
    run(10);
    saved = level;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, (i % 3) == 0, 12'h5A5, 8'd0);
    check("s4_level_held", int'(level), int'(saved));
    check("s4_pwm_low",    int'(pwm),   0);
    check("s4_period_low", int'(period), 0);
    check("s4_busy_held",  int'(busy),  1);
    run(40);

    // Reset mid-fade
    cyc(1'b0, 1'b1, 1'b1, 12'h000, 8'd0);
    run(3);
    cyc(1'b1, 1'b1, 1'b0, 12'h000, 8'd0);
    check("s6_level", int'(level),  0);
    check("s6_busy",  int'(busy),   0);
    check("s6_pwm",   int'(pwm),    0);
    check("s6_per",   int'(period), 0);
    run(3);
    check("s6_level_after", int'(level), 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 19) != 0,
          $urandom_range(0, 29) == 0, 12'($urandom), 8'($urandom_range(0, 3)));
    end
    run(2);

    @(negedge clk); #1;
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
